cpu_bus_responder: RTL and testbench
====================================

# cpu_bus_responder

Bus responder for the 20-bit address / 16-bit data CPU bus with active-low READn/WRn strobes and a WAITn ready line. It accepts single-word read and write strobes from a bus master, forwards each access to the SDRAM controller over a req/ack port, and drives read data and WAITn back to the master. It sits between the CPU and the SDRAM arbiter in the SDRAM_SVGA datapath.

## Interface
- TIMEOUT_CYCLES, 0: maximum cycles MEM_REQ may stay high without MEM_ACK; 0 disables the watchdog.
- CLK  in  1  single clock; all logic on posedge.
- RSTn  in  1  reset: synchronous and active-low.
- ADDRESS  in  20  master address, valid while a strobe is low.
- DATA_OUT  in  16  master write data, valid while WRn is low.
- READn  in  1  read strobe, active low.
- WRn  in  1  write strobe, active low.
- DATA_IN  out  16  read data to master, registered.
- WAITn  out  1  completion: high for exactly one cycle per access, low otherwise.
- MEM_REQ  out  1  memory request, held until MEM_ACK or timeout.
- MEM_WE  out  1  1 = write, 0 = read; stable while MEM_REQ is high.
- MEM_ADDR  out  20  latched address.
- MEM_WDATA  out  16  latched write data.
- MEM_ACK  in  1  one-cycle completion from the controller.
- MEM_RDATA  in  16  read data, valid with MEM_ACK.
- BUS_ERR  out  1  one-cycle pulse on timeout or illegal strobe combination.

## Operation
- Reset values: DATA_IN=0, WAITn=0, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, BUS_ERR=0, state IDLE, posted buffer empty.
- States: IDLE, ACCESS, DONE, RELEASE.
- IDLE: when a strobe is low, latch ADDRESS (and DATA_OUT for writes), set MEM_REQ=1 and MEM_WE, then go to ACCESS.
- ACCESS: on MEM_ACK, clear MEM_REQ. For a read, load DATA_IN from MEM_RDATA. Set WAITn=1 and go to DONE.
- DONE: set WAITn=0 and go to RELEASE. DATA_IN holds its value until the next read completes.
- RELEASE: return to IDLE only once READn and WRn are both high. One strobe assertion is never serviced twice.
- READn and WRn both low in IDLE: perform the write, ignore the read, pulse BUS_ERR.
- Timeout (TIMEOUT_CYCLES>0): count cycles in ACCESS. When the count reaches TIMEOUT_CYCLES with no ACK, drop MEM_REQ, set DATA_IN=16'hFFFF for reads (writes are discarded), pulse BUS_ERR and WAITn together, then go to DONE.
- If MEM_ACK and the timeout occur in the same cycle, ACK wins and BUS_ERR stays low.
- MEM_ACK outside ACCESS or a posted drain is ignored.

## Timing
- Strobe first sampled low at edge t: MEM_REQ is high after t.
- MEM_ACK sampled at edge u: WAITn and DATA_IN are valid after u, and WAITn is low again after u+1.
- Minimum read latency, strobe sample to WAITn high: 2 edges (ACK one cycle after REQ).
- WAITn comes from a flop. The master samples it on the falling edge, so DATA_IN must be stable for the whole high cycle of WAITn.
- Reset mid-access: at the next edge all outputs take their reset values, MEM_REQ drops with no ACK wait, and any posted write is lost. A strobe still low after reset is treated as a new access.

## Configuration
- POSTED_WRITE_EN defined:
  - A write in IDLE with the buffer empty latches address/data and sets WAITn=1 at the capture edge, then goes to DONE.
  - The buffer drains on MEM_REQ/MEM_WE in parallel with DONE/RELEASE.
  - Any new strobe waits in IDLE until the drain's MEM_ACK.
  - The timeout applies to the drain and pulses BUS_ERR only; WAITn is not pulsed.
- Not defined: writes complete only after MEM_ACK, the same as reads.

## Structure
- Package cpu_bus_pkg holds:
  - ADDR_W=20, DATA_W=16 and ERR_DATA=16'hFFFF.
  - The state enum (IDLE, ACCESS, DONE, RELEASE).
- One sub-module, bus_timeout_counter: it has clear and enable inputs, a timeout pulse output, and width $clog2(TIMEOUT_CYCLES+1). It ties off when TIMEOUT_CYCLES=0.

## Test plan
- Read 20'h00010, ACK 3 cycles after REQ with 16'h1234 -> MEM_WE=0; WAITn high for exactly one cycle; DATA_IN=16'h1234; MEM_REQ low after the ACK edge.
- Write 20'h00020 with 16'hABCD, macro off -> MEM_WE=1 and MEM_WDATA=16'hABCD held until ACK; WAITn pulses only on the edge after the ACK.
- Macro on: write 16'h5555 to 20'h00030, then a read at 20'h00031 immediately -> WAITn pulses at the write capture edge; the read's MEM_REQ does not rise until the write ACK.
- TIMEOUT_CYCLES=8, read with no ACK -> MEM_REQ drops after 8 cycles; DATA_IN=16'hFFFF; BUS_ERR and WAITn each pulse for one cycle.
- READn held low for 5 cycles after a completed read -> exactly one MEM_REQ; the FSM stays in RELEASE until READn rises.
- RSTn low during ACCESS with READn low -> all outputs reset at the next edge; after release, a new MEM_REQ is issued. Separately, READn and WRn low together -> one write plus a BUS_ERR pulse.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared widths, error data pattern and FSM state encoding for the CPU bus responder.
package cpu_bus_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;

    localparam logic [DATA_W-1:0] ERR_DATA = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Either active-low strobe asserted.
    function automatic logic strobe_active(input logic read_n, input logic wr_n);
        return !read_n || !wr_n;
    endfunction

endpackage

// File: rtl/cpu_bus_responder_if.sv
// CPU-side strobe bus and SDRAM-side req/ack port of the responder.
interface cpu_bus_responder_if;
    import cpu_bus_pkg::*;

    // Master side: a low READn/WRn starts one access. WAITn high for one cycle
    // completes it; the strobe must then rise before another access is taken.
    // Memory side: MEM_REQ with MEM_WE/MEM_ADDR/MEM_WDATA is held stable until
    // a one-cycle MEM_ACK (carrying MEM_RDATA for reads) or a timeout.
    logic [ADDR_W-1:0] ADDRESS;
    logic [DATA_W-1:0] DATA_OUT;
    logic              READn;
    logic              WRn;
    logic [DATA_W-1:0] DATA_IN;
    logic              WAITn;
    logic              MEM_REQ;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic              MEM_ACK;
    logic [DATA_W-1:0] MEM_RDATA;
    logic              BUS_ERR;

    modport slave (
        input  ADDRESS, DATA_OUT, READn, WRn, MEM_ACK, MEM_RDATA,
        output DATA_IN, WAITn, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, BUS_ERR
    );

    modport master (
        output ADDRESS, DATA_OUT, READn, WRn, MEM_ACK, MEM_RDATA,
        input  DATA_IN, WAITn, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, BUS_ERR
    );

endinterface

// File: rtl/cpu_bus_responder_bus_timeout_counter.sv
// Watchdog for an outstanding memory request; TIMEOUT_CYCLES=0 removes it entirely.
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_count
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] count;

            // Fires on the TIMEOUT_CYCLES-th enabled edge; saturates until cleared.
            always_ff @(posedge clk) begin
                if (!rst_n || clear) begin
                    count <= '0;
                end else if (enable && count != LAST) begin
                    count <= count + CW'(1);
                end
            end

            assign timeout = enable && (count == LAST);
        end else begin : g_none
            logic unused;
            assign unused  = ^{clk, rst_n, clear, enable};
            assign timeout = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/cpu_bus_responder.sv
// CPU strobe bus to SDRAM req/ack responder. Define POSTED_WRITE_EN to
// complete writes at capture and drain them to memory in the background.
module cpu_bus_responder
    import cpu_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic               CLK,
    input  logic               RSTn,
    cpu_bus_responder_if.slave bus,
    output logic [1:0]         dbg_state
);

    state_t            state;
    logic [DATA_W-1:0] data_in;
    logic              waitn;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              bus_err;
    logic              drain_busy;
    logic              timeout;
    logic              strobe;

    assign strobe = strobe_active(bus.READn, bus.WRn);

    // Counts only while a request is outstanding, so it covers ACCESS and a posted drain alike.
    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (CLK),
        .rst_n  (RSTn),
        .clear  (!mem_req),
        .enable (mem_req),
        .timeout(timeout)
    );

`ifndef POSTED_WRITE_EN
    assign drain_busy = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state     <= IDLE;
            data_in   <= '0;
            waitn     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            bus_err   <= 1'b0;
`ifdef POSTED_WRITE_EN
            drain_busy <= 1'b0;
`endif
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    // A pending drain owns the memory port; new strobes wait for its ACK.
                    if (strobe && !drain_busy) begin
                        mem_addr <= bus.ADDRESS;
                        mem_req  <= 1'b1;
                        mem_we   <= !bus.WRn;
                        if (!bus.WRn) begin
                            mem_wdata <= bus.DATA_OUT;
                            bus_err   <= !bus.READn;
`ifdef POSTED_WRITE_EN
                            waitn      <= 1'b1;
                            drain_busy <= 1'b1;
                            state      <= DONE;
`else
                            state      <= ACCESS;
`endif
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // ACK takes priority over a timeout landing on the same edge.
                    if (bus.MEM_ACK) begin
                        mem_req <= 1'b0;
                        waitn   <= 1'b1;
                        state   <= DONE;
                        if (!mem_we) begin
                            data_in <= bus.MEM_RDATA;
                        end
                    end else if (timeout) begin
                        mem_req <= 1'b0;
                        waitn   <= 1'b1;
                        bus_err <= 1'b1;
                        state   <= DONE;
                        if (!mem_we) begin
                            data_in <= ERR_DATA;
                        end
                    end
                end
                DONE: begin
                    waitn <= 1'b0;
                    state <= RELEASE;
                end
                RELEASE: begin
                    if (bus.READn && bus.WRn) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
`ifdef POSTED_WRITE_EN
            // Background drain: a timeout drops the write and flags it without touching WAITn.
            if (drain_busy) begin
                if (bus.MEM_ACK) begin
                    mem_req    <= 1'b0;
                    drain_busy <= 1'b0;
                end else if (timeout) begin
                    mem_req    <= 1'b0;
                    drain_busy <= 1'b0;
                    bus_err    <= 1'b1;
                end
            end
`endif
        end
    end

    assign bus.DATA_IN   = data_in;
    assign bus.WAITn     = waitn;
    assign bus.MEM_REQ   = mem_req;
    assign bus.MEM_WE    = mem_we;
    assign bus.MEM_ADDR  = mem_addr;
    assign bus.MEM_WDATA = mem_wdata;
    assign bus.BUS_ERR   = bus_err;
    assign dbg_state     = state;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Self-checking bench for cpu_bus_responder (timeout 8); honours POSTED_WRITE_EN.
module tb_cpu_bus_responder;
    import cpu_bus_pkg::*;

    localparam int TO = 8;

    logic       CLK;
    logic       RSTn;
    logic [1:0] dbg_state;

    cpu_bus_responder_if bus ();

    cpu_bus_responder #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] last_rd;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Every WAITn-high cycle retires one access; DATA_IN must match the queued value.
    initial begin
        logic [DATA_W-1:0] exp_v;
        forever begin
            @(negedge CLK);
            if (RSTn === 1'b1 && bus.WAITn === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL waitn_unexpected: WAITn=1 with no access outstanding");
                end else begin
                    exp_v = exp_q.pop_front();
                    if (bus.DATA_IN !== exp_v) begin
                        errors++;
                        $display("FAIL data_in: got %h want %h", bus.DATA_IN, exp_v);
                    end
                end
            end
        end
    end

    task automatic release_bus();
        bus.READn = 1'b1;
        bus.WRn   = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic wait_req(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            seen = (bus.MEM_REQ === 1'b1);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_req_wait: MEM_REQ %b, want 1 within 10 cycles", name, bus.MEM_REQ);
        end
    endtask

    task automatic test_reset();
        RSTn          = 1'b0;
        bus.READn     = 1'b1;
        bus.WRn       = 1'b1;
        bus.MEM_ACK   = 1'b0;
        bus.MEM_RDATA = '0;
        bus.ADDRESS   = '0;
        bus.DATA_OUT  = '0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({bus.WAITn, bus.MEM_REQ, bus.MEM_WE, bus.BUS_ERR} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000", {bus.WAITn, bus.MEM_REQ, bus.MEM_WE, bus.BUS_ERR});
        end
        checks++;
        if ({bus.DATA_IN, bus.MEM_ADDR, bus.MEM_WDATA} !== 52'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {bus.DATA_IN, bus.MEM_ADDR, bus.MEM_WDATA});
        end
        checks++;
        if (dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE);
        end
        RSTn    = 1'b1;
        last_rd = '0;
        @(negedge CLK);
    endtask

    task automatic test_read();
        bus.ADDRESS = 20'h00010;
        bus.READn   = 1'b0;
        exp_q.push_back(16'h1234);
        last_rd = 16'h1234;
        wait_req("read");
        checks++;
        if ({bus.MEM_WE, bus.MEM_ADDR} !== {1'b0, 20'h00010}) begin
            errors++;
            $display("FAIL read_cmd: got we=%b addr=%h want 0/00010", bus.MEM_WE, bus.MEM_ADDR);
        end
        repeat (2) begin
            @(negedge CLK);
            checks++;
            if ({bus.MEM_REQ, bus.WAITn} !== 2'b10) begin
                errors++;
                $display("FAIL read_hold: got req/waitn=%b want 10", {bus.MEM_REQ, bus.WAITn});
            end
        end
        bus.MEM_ACK   = 1'b1;
        bus.MEM_RDATA = 16'h1234;
        @(negedge CLK);
        bus.MEM_ACK = 1'b0;
        checks++;
        if ({bus.MEM_REQ, bus.WAITn} !== 2'b01) begin
            errors++;
            $display("FAIL read_ack: got req/waitn=%b want 01", {bus.MEM_REQ, bus.WAITn});
        end
        @(negedge CLK);
        checks++;
        if ({bus.WAITn, bus.DATA_IN} !== {1'b0, 16'h1234}) begin
            errors++;
            $display("FAIL read_after: got waitn=%b data=%h want 0/1234", bus.WAITn, bus.DATA_IN);
        end
        bus.READn = 1'b1;
        @(negedge CLK);
        checks++;
        if (dbg_state !== IDLE) begin
            errors++;
            $display("FAIL read_idle: got state %0d want %0d", dbg_state, IDLE);
        end
    endtask

    task automatic test_hold_strobe();
        bus.ADDRESS = 20'h00040;
        bus.READn   = 1'b0;
        exp_q.push_back(16'h2222);
        last_rd = 16'h2222;
        @(negedge CLK);
        checks++;
        if (bus.MEM_REQ !== 1'b1) begin
            errors++;
            $display("FAIL hold_req: got %b want 1", bus.MEM_REQ);
        end
        bus.MEM_ACK   = 1'b1;
        bus.MEM_RDATA = 16'h2222;
        @(negedge CLK);
        bus.MEM_ACK = 1'b0;
        checks++;
        if (bus.WAITn !== 1'b1) begin
            errors++;
            $display("FAIL hold_min_latency: got waitn %b want 1 two edges after strobe", bus.WAITn);
        end
        repeat (5) begin
            @(negedge CLK);
            checks++;
            if ({bus.MEM_REQ, dbg_state} !== {1'b0, RELEASE}) begin
                errors++;
                $display("FAIL hold_release: got req=%b state=%0d want 0/%0d", bus.MEM_REQ, dbg_state, RELEASE);
            end
        end
        bus.READn = 1'b1;
        @(negedge CLK);
        checks++;
        if (dbg_state !== IDLE) begin
            errors++;
            $display("FAIL hold_idle: got state %0d want %0d", dbg_state, IDLE);
        end
    endtask

    task automatic test_write();
        bus.ADDRESS  = 20'h00020;
        bus.DATA_OUT = 16'hABCD;
        bus.WRn      = 1'b0;
        exp_q.push_back(last_rd);
`ifdef POSTED_WRITE_EN
        @(negedge CLK);
        checks++;
        if ({bus.WAITn, bus.MEM_REQ, bus.MEM_WE, bus.MEM_WDATA} !== {3'b111, 16'hABCD}) begin
            errors++;
            $display("FAIL write_posted_capture: got waitn/req/we=%b wdata=%h want 111/abcd",
                     {bus.WAITn, bus.MEM_REQ, bus.MEM_WE}, bus.MEM_WDATA);
        end
        bus.WRn = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            checks++;
            if ({bus.MEM_REQ, bus.MEM_WE, bus.MEM_WDATA} !== {2'b11, 16'hABCD}) begin
                errors++;
                $display("FAIL write_drain_hold: got req/we=%b wdata=%h want 11/abcd",
                         {bus.MEM_REQ, bus.MEM_WE}, bus.MEM_WDATA);
            end
        end
        bus.MEM_ACK = 1'b1;
        @(negedge CLK);
        bus.MEM_ACK = 1'b0;
        checks++;
        if (bus.MEM_REQ !== 1'b0) begin
            errors++;
            $display("FAIL write_drain_ack: got req %b want 0", bus.MEM_REQ);
        end
`else
        wait_req("write");
        checks++;
        if ({bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WDATA} !== {1'b1, 20'h00020, 16'hABCD}) begin
            errors++;
            $display("FAIL write_cmd: got we=%b addr=%h wdata=%h want 1/00020/abcd",
                     bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WDATA);
        end
        repeat (2) begin
            @(negedge CLK);
            checks++;
            if ({bus.MEM_REQ, bus.MEM_WE, bus.WAITn, bus.MEM_WDATA} !== {3'b110, 16'hABCD}) begin
                errors++;
                $display("FAIL write_hold: got req/we/waitn=%b wdata=%h want 110/abcd",
                         {bus.MEM_REQ, bus.MEM_WE, bus.WAITn}, bus.MEM_WDATA);
            end
        end
        bus.MEM_ACK = 1'b1;
        @(negedge CLK);
        bus.MEM_ACK = 1'b0;
        checks++;
        if ({bus.WAITn, bus.MEM_REQ} !== 2'b10) begin
            errors++;
            $display("FAIL write_ack: got waitn/req=%b want 10", {bus.WAITn, bus.MEM_REQ});
        end
        @(negedge CLK);
        checks++;
        if (bus.WAITn !== 1'b0) begin
            errors++;
            $display("FAIL write_waitn_drop: got %b want 0", bus.WAITn);
        end
`endif
        release_bus();
    endtask

`ifdef POSTED_WRITE_EN
    task automatic test_posted_then_read();
        bus.ADDRESS  = 20'h00030;
        bus.DATA_OUT = 16'h5555;
        bus.WRn      = 1'b0;
        exp_q.push_back(last_rd);
        @(negedge CLK);
        checks++;
        if ({bus.WAITn, bus.MEM_WE, bus.MEM_ADDR} !== {2'b11, 20'h00030}) begin
            errors++;
            $display("FAIL posted_capture: got waitn/we=%b addr=%h want 11/00030",
                     {bus.WAITn, bus.MEM_WE}, bus.MEM_ADDR);
        end
        bus.WRn = 1'b1;
        repeat (2) @(negedge CLK);
        bus.ADDRESS = 20'h00031;
        bus.READn   = 1'b0;
        exp_q.push_back(16'h7777);
        last_rd = 16'h7777;
        repeat (3) begin
            @(negedge CLK);
            checks++;
            if ({bus.MEM_REQ, bus.MEM_WE, bus.MEM_ADDR} !== {2'b11, 20'h00030}) begin
                errors++;
                $display("FAIL posted_read_blocked: got req/we=%b addr=%h want 11/00030",
                         {bus.MEM_REQ, bus.MEM_WE}, bus.MEM_ADDR);
            end
        end
        bus.MEM_ACK = 1'b1;
        @(negedge CLK);
        bus.MEM_ACK = 1'b0;
        checks++;
        if (bus.MEM_REQ !== 1'b0) begin
            errors++;
            $display("FAIL posted_drain_done: got req %b want 0", bus.MEM_REQ);
        end
        wait_req("posted_read");
        checks++;
        if ({bus.MEM_WE, bus.MEM_ADDR} !== {1'b0, 20'h00031}) begin
            errors++;
            $display("FAIL posted_read_cmd: got we=%b addr=%h want 0/00031", bus.MEM_WE, bus.MEM_ADDR);
        end
        bus.MEM_ACK   = 1'b1;
        bus.MEM_RDATA = 16'h7777;
        @(negedge CLK);
        bus.MEM_ACK = 1'b0;
        checks++;
        if (bus.WAITn !== 1'b1) begin
            errors++;
            $display("FAIL posted_read_waitn: got %b want 1", bus.WAITn);
        end
        release_bus();
    endtask
`endif

    task automatic test_timeout();
        bus.ADDRESS = 20'h00050;
        bus.READn   = 1'b0;
        exp_q.push_back(ERR_DATA);
        last_rd = ERR_DATA;
        wait_req("timeout");
        repeat (TO - 1) begin
            @(negedge CLK);
            checks++;
            if ({bus.MEM_REQ, bus.BUS_ERR, bus.WAITn} !== 3'b100) begin
                errors++;
                $display("FAIL timeout_wait: got req/err/waitn=%b want 100", {bus.MEM_REQ, bus.BUS_ERR, bus.WAITn});
            end
        end
        @(negedge CLK);
        checks++;
        if ({bus.MEM_REQ, bus.BUS_ERR, bus.WAITn} !== 3'b011) begin
            errors++;
            $display("FAIL timeout_fire: got req/err/waitn=%b want 011", {bus.MEM_REQ, bus.BUS_ERR, bus.WAITn});
        end
        @(negedge CLK);
        checks++;
        if ({bus.BUS_ERR, bus.WAITn} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_pulse: got err/waitn=%b want 00", {bus.BUS_ERR, bus.WAITn});
        end
        release_bus();
    endtask

    task automatic test_ack_timeout_race();
        bus.ADDRESS = 20'h00051;
        bus.READn   = 1'b0;
        exp_q.push_back(16'h3C3C);
        last_rd = 16'h3C3C;
        wait_req("race");
        repeat (TO - 1) @(negedge CLK);
        bus.MEM_ACK   = 1'b1;
        bus.MEM_RDATA = 16'h3C3C;
        @(negedge CLK);
        bus.MEM_ACK = 1'b0;
        checks++;
        if ({bus.MEM_REQ, bus.BUS_ERR, bus.WAITn} !== 3'b001) begin
            errors++;
            $display("FAIL race_ack_wins: got req/err/waitn=%b want 001", {bus.MEM_REQ, bus.BUS_ERR, bus.WAITn});
        end
        release_bus();
    endtask

    task automatic test_both_low();
        logic exp_w;
`ifdef POSTED_WRITE_EN
        exp_w = 1'b1;
`else
        exp_w = 1'b0;
`endif
        bus.ADDRESS  = 20'h00060;
        bus.DATA_OUT = 16'h0F0F;
        bus.READn    = 1'b0;
        bus.WRn      = 1'b0;
        exp_q.push_back(last_rd);
        @(negedge CLK);
        checks++;
        if ({bus.BUS_ERR, bus.MEM_REQ, bus.MEM_WE, bus.WAITn} !== {3'b111, exp_w}) begin
            errors++;
            $display("FAIL both_capture: got err/req/we/waitn=%b want 111%b",
                     {bus.BUS_ERR, bus.MEM_REQ, bus.MEM_WE, bus.WAITn}, exp_w);
        end
        checks++;
        if ({bus.MEM_ADDR, bus.MEM_WDATA} !== {20'h00060, 16'h0F0F}) begin
            errors++;
            $display("FAIL both_write_data: got addr=%h wdata=%h want 00060/0f0f", bus.MEM_ADDR, bus.MEM_WDATA);
        end
        @(negedge CLK);
        checks++;
        if (bus.BUS_ERR !== 1'b0) begin
            errors++;
            $display("FAIL both_err_pulse: got %b want 0", bus.BUS_ERR);
        end
        bus.MEM_ACK = 1'b1;
        @(negedge CLK);
        bus.MEM_ACK = 1'b0;
        checks++;
        if (bus.MEM_REQ !== 1'b0) begin
            errors++;
            $display("FAIL both_ack: got req %b want 0", bus.MEM_REQ);
        end
        release_bus();
    endtask

    task automatic test_ack_ignored();
        bus.MEM_RDATA = 16'hBEEF;
        bus.MEM_ACK   = 1'b1;
        @(negedge CLK);
        bus.MEM_ACK = 1'b0;
        @(negedge CLK);
        checks++;
        if ({bus.DATA_IN, bus.MEM_REQ, dbg_state} !== {last_rd, 1'b0, IDLE}) begin
            errors++;
            $display("FAIL stray_ack: got data=%h req=%b state=%0d want %h/0/%0d",
                     bus.DATA_IN, bus.MEM_REQ, dbg_state, last_rd, IDLE);
        end
    endtask

    task automatic test_reset_mid_access();
        bus.ADDRESS = 20'h00070;
        bus.READn   = 1'b0;
        wait_req("mid_reset");
        @(negedge CLK);
        RSTn = 1'b0;
        @(negedge CLK);
        checks++;
        if ({bus.WAITn, bus.MEM_REQ, bus.MEM_WE, bus.BUS_ERR, bus.DATA_IN, bus.MEM_ADDR} !== 40'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got req=%b data=%h addr=%h want all 0",
                     bus.MEM_REQ, bus.DATA_IN, bus.MEM_ADDR);
        end
        checks++;
        if (dbg_state !== IDLE) begin
            errors++;
            $display("FAIL mid_reset_state: got %0d want %0d", dbg_state, IDLE);
        end
        RSTn = 1'b1;
        exp_q.push_back(16'h4321);
        last_rd = 16'h4321;
        wait_req("after_reset");
        checks++;
        if ({bus.MEM_WE, bus.MEM_ADDR} !== {1'b0, 20'h00070}) begin
            errors++;
            $display("FAIL after_reset_cmd: got we=%b addr=%h want 0/00070", bus.MEM_WE, bus.MEM_ADDR);
        end
        bus.MEM_ACK   = 1'b1;
        bus.MEM_RDATA = 16'h4321;
        @(negedge CLK);
        bus.MEM_ACK = 1'b0;
        checks++;
        if (bus.WAITn !== 1'b1) begin
            errors++;
            $display("FAIL after_reset_waitn: got %b want 1", bus.WAITn);
        end
        release_bus();
    endtask

    initial begin
        test_reset();
        test_read();
        test_hold_strobe();
        test_write();
`ifdef POSTED_WRITE_EN
        test_posted_then_read();
`endif
        test_timeout();
        test_ack_timeout_race();
        test_both_low();
        test_ack_ignored();
        test_reset_mid_access();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d accesses never completed, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
